// File: rtl/ct_ciu_regs_arb.sv
`default_nettype none
// ============================================================================
// Module   : ct_ciu_regs_arb
// Purpose  : Round-robin arbiter/sequencer that shares one ct_ciu_regs_kid
//            CSR bank among NUM_REQ requesters. One transaction in flight:
//            grant (IDLE) -> single-cycle bank access (ACC) -> held response
//            (RSP) until the owner acknowledges.
// Ports    : forever_cpuclk / cpurst          clock, async active-high reset
//            req_vld/wen/idx/wdata/l2of_wen   per-requester request buses
//            req_gnt                          one-hot accept pulse
//            rsp_vld/rsp_ack/rsp_rdata/err    held response handshake
//            regs_sel_final_x/regs_wen/...    bank access bus
//            x_csr_value                      bank read data (comb. on idx)
// Revision : 1.0 - initial release
// ============================================================================
module ct_ciu_regs_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ-1:0]      req_wen,
    input  logic [4*NUM_REQ-1:0]    req_idx,
    input  logic [64*NUM_REQ-1:0]   req_wdata,
    input  logic [4*NUM_REQ-1:0]    req_l2of_wen,
    output logic [NUM_REQ-1:0]      req_gnt,
    output logic [NUM_REQ-1:0]      rsp_vld,
    input  logic [NUM_REQ-1:0]      rsp_ack,
    output logic [63:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    regs_sel_final_x,
    output logic                    regs_wen,
    output logic [3:0]              regs_idx,
    output logic [63:0]             regs_wdata_final,
    output logic [3:0]              regs_l2of_wen,
    input  logic [63:0]             x_csr_value
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_owner;
    logic                   r_wen;
    logic [3:0]             r_idx;
    logic [63:0]            r_wdata;
    logic [3:0]             r_l2of;
    logic [63:0]            r_rdata;
    logic                   r_err;

    logic                   w_found;
    logic [PTR_W-1:0]       w_win;
    logic [NUM_REQ-1:0]     w_win_oh;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic                   w_legal_rd;
    logic                   w_legal_wr;
    logic                   w_illegal;
    logic [PTR_W-1:0]       w_ptr_next;

    // Round-robin scan starting at r_ptr; first asserted valid wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_vld[PTR_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_ptr_next = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Index 5 (TEEM) is readable but read-only.
    always_comb begin
        w_legal_rd = 1'b0;
        w_legal_wr = 1'b0;
        case (r_idx)
            4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
                w_legal_rd = 1'b1;
                w_legal_wr = 1'b1;
            end
            4'h5:    w_legal_rd = 1'b1;
            default: ;
        endcase
    end

    assign w_illegal = r_wen ? !w_legal_wr : !w_legal_rd;

    // State register
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and strobe outputs
    always_comb begin
        w_next_state     = r_state;
        req_gnt          = '0;
        rsp_vld          = '0;
        regs_sel_final_x = 1'b0;
        regs_wen         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_gnt      = w_win_oh;
                    w_next_state = ST_ACC;
                end
            end
            ST_ACC: begin
                regs_sel_final_x = 1'b1;
                regs_wen         = r_wen & w_legal_wr;
                w_next_state     = ST_RSP;
            end
            ST_RSP: begin
                rsp_vld = w_owner_oh;
                if (rsp_ack[r_owner]) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, read capture and round-robin pointer
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_wen   <= 1'b0;
            r_idx   <= 4'h0;
            r_wdata <= 64'h0;
            r_l2of  <= 4'h0;
            r_rdata <= 64'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_wen   <= req_wen[w_win];
                        r_idx   <= req_idx[{w_win, 2'b00} +: 4];
                        r_wdata <= req_wdata[{w_win, 6'd0} +: 64];
                        r_l2of  <= req_l2of_wen[{w_win, 2'b00} +: 4];
                    end
                end
                ST_ACC: begin
                    // Bank read is combinational on regs_idx, so this is the
                    // pre-write value when the access is a write.
                    r_rdata <= w_illegal ? 64'h0 : x_csr_value;
                    r_err   <= w_illegal;
                end
                ST_RSP: begin
                    if (rsp_ack[r_owner]) r_ptr <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign regs_idx         = r_idx;
    assign regs_wdata_final = r_wdata;
    assign regs_l2of_wen    = r_l2of;
    assign rsp_rdata        = r_rdata;
    assign rsp_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ct_ciu_regs_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_ciu_regs_arb
// Purpose  : Directed self-checking bench for ct_ciu_regs_arb with a small
//            behavioural CSR bank attached to the bank bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_ciu_regs_arb;

    localparam int N = 4;

    logic              forever_cpuclk;
    logic              cpurst;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_wen;
    logic [4*N-1:0]    req_idx;
    logic [64*N-1:0]   req_wdata;
    logic [4*N-1:0]    req_l2of_wen;
    logic [N-1:0]      req_gnt;
    logic [N-1:0]      rsp_vld;
    logic [N-1:0]      rsp_ack;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    logic              regs_sel_final_x;
    logic              regs_wen;
    logic [3:0]        regs_idx;
    logic [63:0]       regs_wdata_final;
    logic [3:0]        regs_l2of_wen;
    logic [63:0]       x_csr_value;

    int n_checks = 0;
    int n_pass   = 0;

    ct_ciu_regs_arb #(.NUM_REQ(N)) dut (
        .forever_cpuclk   (forever_cpuclk),
        .cpurst           (cpurst),
        .req_vld          (req_vld),
        .req_wen          (req_wen),
        .req_idx          (req_idx),
        .req_wdata        (req_wdata),
        .req_l2of_wen     (req_l2of_wen),
        .req_gnt          (req_gnt),
        .rsp_vld          (rsp_vld),
        .rsp_ack          (rsp_ack),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .regs_sel_final_x (regs_sel_final_x),
        .regs_wen         (regs_wen),
        .regs_idx         (regs_idx),
        .regs_wdata_final (regs_wdata_final),
        .regs_l2of_wen    (regs_l2of_wen),
        .x_csr_value      (x_csr_value)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Behavioural CSR bank: SMPEN(4)=1, L2RA(8)=0x1234, idx 9 a marker value.
    logic [63:0] bank [16];
    assign x_csr_value = bank[regs_idx];
    always @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < 16; i++) bank[i] <= 64'h0;
            bank[4] <= 64'h1;
            bank[8] <= 64'h1234;
            bank[9] <= 64'hA5A5_0000_5A5A_0001;
        end else if (regs_sel_final_x && regs_wen) begin
            bank[regs_idx] <= regs_wdata_final;
        end
    end

    function automatic logic [159:0] all_outs();
        return {req_gnt, rsp_vld, rsp_rdata, rsp_err, regs_sel_final_x,
                regs_wen, regs_idx, regs_wdata_final, regs_l2of_wen};
    endfunction

    task automatic clear_inputs();
        req_vld = '0; req_wen = '0; req_idx = '0;
        req_wdata = '0; req_l2of_wen = '0; rsp_ack = '0;
    endtask

    task automatic do_reset();
        cpurst = 1'b1;
        clear_inputs();
        @(negedge forever_cpuclk);
        @(negedge forever_cpuclk);
        cpurst = 1'b0;
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        clear_inputs();
        @(negedge forever_cpuclk);
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if (all_outs() !== 160'h0) $display("FAIL reset_outputs: got %h want 0", all_outs());
        else n_pass++;
        cpurst = 1'b0;
    endtask

    task automatic test_read();
        do_reset();
        req_vld = 4'b0001; req_idx = 16'h0008;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0001) $display("FAIL rd_gnt: got %b want 0001", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = '0;
        #1;
        n_checks++;
        if ({regs_sel_final_x, regs_wen, regs_idx, req_gnt} !== {1'b1, 1'b0, 4'h8, 4'b0000})
            $display("FAIL rd_acc: got sel=%b wen=%b idx=%h gnt=%b want 1 0 8 0000",
                     regs_sel_final_x, regs_wen, regs_idx, req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if ({rsp_vld, rsp_rdata, rsp_err} !== {4'b0001, 64'h1234, 1'b0})
            $display("FAIL rd_rsp: got vld=%b rdata=%h err=%b want 0001 1234 0",
                     rsp_vld, rsp_rdata, rsp_err);
        else n_pass++;
        rsp_ack = 4'b0001;
        @(negedge forever_cpuclk);
        rsp_ack = '0;
        #1;
        n_checks++;
        if (rsp_vld !== 4'b0000) $display("FAIL rd_rsp_clear: got %b want 0000", rsp_vld);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        do_reset();
        req_vld = 4'b1111; req_idx = 16'h8888;
        for (int n = 0; n < 5; n++) begin
            exp = 4'b0001 << (n % 4);
            #1;
            n_checks++;
            if (req_gnt !== exp) $display("FAIL b2b_gnt%0d: got %b want %b", n, req_gnt, exp);
            else n_pass++;
            @(negedge forever_cpuclk);
            #1;
            n_checks++;
            if ({req_gnt, regs_sel_final_x} !== {4'b0000, 1'b1})
                $display("FAIL b2b_acc%0d: got gnt=%b sel=%b want 0000 1", n, req_gnt, regs_sel_final_x);
            else n_pass++;
            @(negedge forever_cpuclk);
            #1;
            n_checks++;
            if ({rsp_vld, req_gnt} !== {exp, 4'b0000})
                $display("FAIL b2b_rsp%0d: got vld=%b gnt=%b want %b 0000", n, rsp_vld, req_gnt, exp);
            else n_pass++;
            rsp_ack = exp;
            @(negedge forever_cpuclk);
            rsp_ack = '0;
        end
        req_vld = '0;
    endtask

    task automatic test_write();
        do_reset();
        req_vld = 4'b0100; req_wen = 4'b0100; req_idx = 16'h0400;
        req_wdata = {64'hDEAD, 64'h0, 64'hBEEF, 64'hCAFE};
        req_l2of_wen = 16'h3A5C;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0100) $display("FAIL wr_gnt: got %b want 0100", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = '0;
        #1;
        n_checks++;
        if ({regs_wen, regs_idx, regs_wdata_final, regs_l2of_wen} !== {1'b1, 4'h4, 64'h0, 4'hA})
            $display("FAIL wr_acc: got wen=%b idx=%h wdata=%h l2of=%h want 1 4 0 a",
                     regs_wen, regs_idx, regs_wdata_final, regs_l2of_wen);
        else n_pass++;
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if ({regs_wen, rsp_vld, rsp_rdata, rsp_err} !== {1'b0, 4'b0100, 64'h1, 1'b0})
            $display("FAIL wr_rsp: got wen=%b vld=%b rdata=%h err=%b want 0 0100 1 0",
                     regs_wen, rsp_vld, rsp_rdata, rsp_err);
        else n_pass++;
        n_checks++;
        if (bank[4] !== 64'h0) $display("FAIL wr_smpen: got %h want 0", bank[4]);
        else n_pass++;
        rsp_ack = 4'b0100;
        @(negedge forever_cpuclk);
        rsp_ack = '0; req_wen = '0;
    endtask

    task automatic test_illegal();
        do_reset();
        req_vld = 4'b0001; req_wen = 4'b0001; req_idx = 16'h0035;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0001) $display("FAIL ill_gnt0: got %b want 0001", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = '0;
        #1;
        n_checks++;
        if ({regs_sel_final_x, regs_wen} !== 2'b10)
            $display("FAIL ill_ro_wen: got sel=%b wen=%b want 1 0", regs_sel_final_x, regs_wen);
        else n_pass++;
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if ({rsp_rdata, rsp_err} !== {64'h0, 1'b1})
            $display("FAIL ill_ro_rsp: got rdata=%h err=%b want 0 1", rsp_rdata, rsp_err);
        else n_pass++;
        rsp_ack = 4'b0001;
        @(negedge forever_cpuclk);
        rsp_ack = '0;
        req_vld = 4'b0011; req_wen = '0;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0010) $display("FAIL ill_ptr_adv: got %b want 0010", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = '0;
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if ({rsp_vld, rsp_rdata, rsp_err} !== {4'b0010, 64'h0, 1'b1})
            $display("FAIL ill_rd_rsp: got vld=%b rdata=%h err=%b want 0010 0 1",
                     rsp_vld, rsp_rdata, rsp_err);
        else n_pass++;
        rsp_ack = 4'b0010;
        @(negedge forever_cpuclk);
        rsp_ack = '0;
    endtask

    task automatic test_hold_ack();
        do_reset();
        req_vld = 4'b0001; req_idx = 16'h8889;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0001) $display("FAIL hold_gnt0: got %b want 0001", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = 4'b1110;
        @(negedge forever_cpuclk);
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({rsp_vld, rsp_rdata, req_gnt} !== {4'b0001, 64'hA5A5_0000_5A5A_0001, 4'b0000})
                $display("FAIL hold_cyc%0d: got vld=%b rdata=%h gnt=%b want 0001 a5a500005a5a0001 0000",
                         i, rsp_vld, rsp_rdata, req_gnt);
            else n_pass++;
            rsp_ack = (i % 2 == 1) ? 4'b1110 : 4'b0000;
            @(negedge forever_cpuclk);
        end
        rsp_ack = 4'b0001;
        #1;
        n_checks++;
        if ({rsp_vld, req_gnt} !== {4'b0001, 4'b0000})
            $display("FAIL hold_ack_cyc: got vld=%b gnt=%b want 0001 0000", rsp_vld, req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        rsp_ack = '0;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0010) $display("FAIL hold_next_gnt: got %b want 0010", req_gnt);
        else n_pass++;
        req_vld = '0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_vld = 4'b0010; req_wen = 4'b0010; req_idx = 16'h0080;
        req_wdata = {64'h0, 64'h0, 64'h5555, 64'h0};
        #1;
        n_checks++;
        if (req_gnt !== 4'b0010) $display("FAIL mrst_gnt: got %b want 0010", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = '0; req_wen = '0;
        #1;
        cpurst = 1'b1;
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if (all_outs() !== 160'h0) $display("FAIL mrst_outputs: got %h want 0", all_outs());
        else n_pass++;
        cpurst = 1'b0;
        req_vld = 4'b0100; req_idx = 16'h0800;
        #1;
        n_checks++;
        if (req_gnt !== 4'b0100) $display("FAIL mrst_fresh_gnt: got %b want 0100", req_gnt);
        else n_pass++;
        @(negedge forever_cpuclk);
        req_vld = '0;
        @(negedge forever_cpuclk);
        #1;
        n_checks++;
        if ({rsp_vld, rsp_rdata, rsp_err} !== {4'b0100, 64'h1234, 1'b0})
            $display("FAIL mrst_rsp: got vld=%b rdata=%h err=%b want 0100 1234 0",
                     rsp_vld, rsp_rdata, rsp_err);
        else n_pass++;
        rsp_ack = 4'b0100;
        @(negedge forever_cpuclk);
        rsp_ack = '0;
    endtask

    initial begin
        cpurst = 1'b1;
        clear_inputs();
        test_reset();
        test_read();
        test_back_to_back();
        test_write();
        test_illegal();
        test_hold_ack();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
